// File: rtl/masked_rmw_mem.sv
// rtl/masked_rmw_mem.sv - byte-masked read-modify-write word memory with registered response
module masked_rmw_mem #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int RETURN_NEW = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  io_enable,
    input  logic                  io_write,
    input  logic [ADDR_W-1:0]     io_addr,
    input  logic [DATA_W-1:0]     io_wdata,
    input  logic [DATA_W/8-1:0]   io_mask,
    output logic [DATA_W-1:0]     io_out,
    output logic                  io_out_valid,
    output logic                  io_err,
    output logic [15:0]           io_wr_count
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic                s1_valid_q, s1_valid_d;
    logic                s1_write_q, s1_write_d;
    logic [ADDR_W-1:0]   s1_addr_q,  s1_addr_d;
    logic [DATA_W-1:0]   s1_wdata_q, s1_wdata_d;
    logic [NB-1:0]       s1_mask_q,  s1_mask_d;

    logic [DATA_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;
    logic [15:0]         wr_count_q, wr_count_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_range;
    logic                commit;
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   merged;

    always_comb begin
        s1_valid_d = io_enable;
        s1_write_d = io_write;
        s1_addr_d  = io_addr;
        s1_wdata_d = io_wdata;
        s1_mask_d  = io_mask;

        in_range = ({1'b0, s1_addr_q} < DEPTH_L);
        old_word = '0;
        if (in_range) begin
            old_word = mem_q[s1_addr_q];
        end

        merged = old_word;
        for (int b = 0; b < NB; b++) begin
            if (s1_mask_q[b]) begin
                merged[8*b +: 8] = s1_wdata_q[8*b +: 8];
            end
        end

        // s1_valid_q clears asynchronously, so a write caught by reset never commits
        commit = s1_valid_q && s1_write_q && in_range && (|s1_mask_q);

        out_valid_d = s1_valid_q;
        err_d       = s1_valid_q && !in_range;
        out_d       = out_q;
        if (s1_valid_q) begin
            if (!in_range) begin
                out_d = '0;
            end else if ((RETURN_NEW != 0) && s1_write_q) begin
                out_d = merged;
            end else begin
                out_d = old_word;
            end
        end

        wr_count_d = wr_count_q;
        if (commit && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_write_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_wdata_q  <= '0;
            s1_mask_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wr_count_q  <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_write_q  <= s1_write_d;
            s1_addr_q   <= s1_addr_d;
            s1_wdata_q  <= s1_wdata_d;
            s1_mask_q   <= s1_mask_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Storage is intentionally not reset; contents survive reset_n pulses.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[s1_addr_q] <= merged;
        end
    end

    assign io_out       = out_q;
    assign io_out_valid = out_valid_q;
    assign io_err       = err_q;
    assign io_wr_count  = wr_count_q;

endmodule

// File: tb/tb_masked_rmw_mem.sv
// tb/tb_masked_rmw_mem.sv - directed vector bench for masked_rmw_mem (DEPTH=6/RETURN_NEW=0 and DEPTH=8/RETURN_NEW=1)
module tb_masked_rmw_mem;

    logic        clk;
    logic        reset_n;
    logic        io_enable;
    logic        io_write;
    logic [2:0]  io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_mask;

    logic [31:0] out_a, out_b;
    logic        valid_a, valid_b, err_a, err_b;
    logic [15:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    masked_rmw_mem #(.DATA_W(32), .DEPTH(6), .ADDR_W(3), .RETURN_NEW(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .io_enable(io_enable), .io_write(io_write),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_mask(io_mask),
        .io_out(out_a), .io_out_valid(valid_a), .io_err(err_a), .io_wr_count(cnt_a)
    );

    masked_rmw_mem #(.DATA_W(32), .DEPTH(8), .ADDR_W(3), .RETURN_NEW(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .io_enable(io_enable), .io_write(io_write),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_mask(io_mask),
        .io_out(out_b), .io_out_valid(valid_b), .io_err(err_b), .io_wr_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        ca;
        logic [31:0] oa;
        logic        cb;
        logic [31:0] ob;
        logic        ea;
        logic [15:0] na;
        logic [15:0] nb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic wr, input logic [2:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask,
                       input logic ca, input logic [31:0] oa,
                       input logic cb, input logic [31:0] ob,
                       input logic ea, input logic [15:0] na, input logic [15:0] nb);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mask = mask;
        v.ca = ca; v.oa = oa; v.cb = cb; v.ob = ob; v.ea = ea; v.na = na; v.nb = nb;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic wr, input logic [2:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        io_enable = en; io_write = wr; io_addr = addr; io_wdata = wdata; io_mask = mask;
    endtask

    initial begin
        //   en wr ad wdata         mk  ca oa            cb ob            ea na     nb
        add(1, 1, 2, 32'hAABBCCDD, 4'hF, 0, 32'h0,        1, 32'hAABBCCDD, 0, 16'd1, 16'd1);
        add(1, 0, 2, 32'h0,        4'h0, 1, 32'hAABBCCDD, 1, 32'hAABBCCDD, 0, 16'd1, 16'd1);
        add(1, 1, 5, 32'h11223344, 4'hF, 0, 32'h0,        1, 32'h11223344, 0, 16'd2, 16'd2);
        add(1, 1, 5, 32'hFFFFFFFF, 4'h5, 1, 32'h11223344, 1, 32'h11FF33FF, 0, 16'd3, 16'd3);
        add(1, 0, 5, 32'h0,        4'h0, 1, 32'h11FF33FF, 1, 32'h11FF33FF, 0, 16'd3, 16'd3);
        add(1, 1, 3, 32'h0,        4'hF, 0, 32'h0,        1, 32'h0,        0, 16'd4, 16'd4);
        add(1, 1, 3, 32'h000000AA, 4'h1, 1, 32'h0,        1, 32'h000000AA, 0, 16'd5, 16'd5);
        add(1, 1, 3, 32'h0000BB00, 4'h2, 1, 32'h000000AA, 1, 32'h0000BBAA, 0, 16'd6, 16'd6);
        add(1, 0, 3, 32'h0,        4'h0, 1, 32'h0000BBAA, 1, 32'h0000BBAA, 0, 16'd6, 16'd6);
        add(1, 1, 7, 32'h12345678, 4'hF, 1, 32'h0,        1, 32'h12345678, 1, 16'd6, 16'd7);
        add(1, 0, 2, 32'h0,        4'h0, 1, 32'hAABBCCDD, 1, 32'hAABBCCDD, 0, 16'd6, 16'd7);
        add(1, 1, 1, 32'h0F0F0F0F, 4'hF, 0, 32'h0,        1, 32'h0F0F0F0F, 0, 16'd7, 16'd8);
        add(1, 1, 1, 32'hFFFFFFFF, 4'h0, 1, 32'h0F0F0F0F, 1, 32'h0F0F0F0F, 0, 16'd7, 16'd8);
        add(1, 0, 1, 32'hFFFFFFFF, 4'hF, 1, 32'h0F0F0F0F, 1, 32'h0F0F0F0F, 0, 16'd7, 16'd8);
        add(1, 0, 1, 32'h0,        4'h0, 1, 32'h0F0F0F0F, 1, 32'h0F0F0F0F, 0, 16'd7, 16'd8);
        add(1, 0, 7, 32'h0,        4'h0, 1, 32'h0,        1, 32'h12345678, 1, 16'd7, 16'd8);
        add(0, 0, 0, 32'h0,        4'h0, 1, 32'h0,        1, 32'h12345678, 0, 16'd7, 16'd8);
        add(1, 0, 5, 32'h0,        4'h0, 1, 32'h11FF33FF, 1, 32'h11FF33FF, 0, 16'd7, 16'd8);

        reset_n = 1'b0;
        drive(0, 0, 0, 32'h0, 4'h0);
        #1;
        check("reset valid_a", {31'b0, valid_a}, 32'd0);
        check("reset out_a", out_a, 32'd0);
        check("reset err_a", {31'b0, err_a}, 32'd0);
        check("reset cnt_a", {16'b0, cnt_a}, 32'd0);
        check("reset valid_b", {31'b0, valid_b}, 32'd0);
        check("reset cnt_b", {16'b0, cnt_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i <= vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < vecs.size())
                drive(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask);
            else
                drive(0, 0, 0, 32'h0, 4'h0);
            @(posedge clk);
            #1;
            if (i >= 1) begin
                vec_t v;
                v = vecs[i-1];
                check($sformatf("v%0d valid_a", i-1), {31'b0, valid_a}, {31'b0, v.en});
                check($sformatf("v%0d valid_b", i-1), {31'b0, valid_b}, {31'b0, v.en});
                check($sformatf("v%0d err_a", i-1), {31'b0, err_a}, {31'b0, v.ea});
                check($sformatf("v%0d err_b", i-1), {31'b0, err_b}, 32'd0);
                if (v.ca) check($sformatf("v%0d out_a", i-1), out_a, v.oa);
                if (v.cb) check($sformatf("v%0d out_b", i-1), out_b, v.ob);
                check($sformatf("v%0d cnt_a", i-1), {16'b0, cnt_a}, {16'b0, v.na});
                check($sformatf("v%0d cnt_b", i-1), {16'b0, cnt_b}, {16'b0, v.nb});
            end
        end

        // Asynchronous reset while a write to addr 4 sits in S1
        @(negedge clk);
        drive(1, 1, 4, 32'h44444444, 4'hF);
        @(negedge clk);
        drive(1, 1, 4, 32'h55555555, 4'hF);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async valid_a", {31'b0, valid_a}, 32'd0);
        check("async valid_b", {31'b0, valid_b}, 32'd0);
        check("async out_a", out_a, 32'd0);
        check("async out_b", out_b, 32'd0);
        check("async err_a", {31'b0, err_a}, 32'd0);
        check("async cnt_a", {16'b0, cnt_a}, 32'd0);
        check("async cnt_b", {16'b0, cnt_b}, 32'd0);
        drive(0, 0, 0, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 0, 4, 32'h0, 4'h0);
        @(negedge clk);
        drive(1, 0, 2, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check("post-reset a4 valid_a", {31'b0, valid_a}, 32'd1);
        check("post-reset a4 out_a", out_a, 32'h44444444);
        check("post-reset a4 out_b", out_b, 32'h44444444);
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check("post-reset a2 out_a", out_a, 32'hAABBCCDD);
        check("post-reset a2 out_b", out_b, 32'hAABBCCDD);
        check("post-reset cnt_a", {16'b0, cnt_a}, 32'd0);
        check("post-reset cnt_b", {16'b0, cnt_b}, 32'd0);
        @(posedge clk);
        #1;
        check("idle valid_a", {31'b0, valid_a}, 32'd0);
        check("idle hold out_b", out_b, 32'hAABBCCDD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/masked_rmw_mem.md
MASKED_RMW_MEM -- requirements
Module: masked_rmw_mem

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8: number of words; need not be a power of two.
REQ-003 Parameter ADDR_W, default 3: address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 Parameter RETURN_NEW, default 0: 0 = io_out returns pre-write word; 1 = io_out returns post-merge word.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 io_enable  input  1  request valid; one request accepted per cycle, no backpressure.
REQ-008 io_write  input  1  1 = masked write, 0 = read only.
REQ-009 io_addr  input  ADDR_W  word address.
REQ-010 io_wdata  input  DATA_W  write data.
REQ-011 io_mask  input  DATA_W/8  byte enables; bit i selects byte i (bits 8i+7:8i).
REQ-012 io_out  output  DATA_W  registered response data.
REQ-013 io_out_valid  output  1  io_out holds a response this cycle.
REQ-014 io_err  output  1  registered; response was to an out-of-range address.
REQ-015 io_wr_count  output  16  count of committed writes, saturating.

Function
REQ-016 Stage S1 register (valid, write, addr, wdata, mask) SHALL load on every edge; s1_valid = io_enable.
REQ-017 During S1, old = mem[s1_addr] read combinationally; merged byte i = mask[i] ? wdata byte i : old byte i.
REQ-018 At the edge ending S1, if s1_valid & s1_write & in-range & mask != 0, mem[s1_addr] SHALL take merged.
REQ-019 At the same edge, io_out_valid SHALL take s1_valid; io_out SHALL take merged if RETURN_NEW=1 and s1_write, else old.
REQ-020 Latency: request presented in cycle N -> io_out_valid high in cycle N+2; throughput one per cycle.
REQ-021 Back-to-back requests to the same address SHALL see the preceding write (commit precedes next S1 read); no stall, no forwarding path needed.
REQ-022 Out-of-range (s1_addr >= DEPTH): no memory write, io_out = 0, io_err = 1 with io_out_valid; io_wr_count unchanged.
REQ-023 io_err SHALL be 0 whenever io_out_valid is 0.
REQ-024 mask == 0 write: memory unchanged, response returned as a read, io_wr_count unchanged.
REQ-025 io_wr_count increments by 1 per committed write (REQ-018); holds at 16'hFFFF.
REQ-026 When io_out_valid is 0, io_out SHALL hold its previous value.
REQ-027 Read-only requests SHALL never modify memory regardless of io_mask/io_wdata.

Reset
REQ-028 While reset_n = 0: s1_valid = 0, io_out_valid = 0, io_out = 0, io_err = 0, io_wr_count = 0.
REQ-029 A write in S1 when reset_n falls SHALL be dropped (asynchronous clear of s1_valid gates the write enable).
REQ-030 Memory contents SHALL NOT be reset; undefined until written (simulation randomizes).
REQ-031 First request accepted on the first rising edge with reset_n = 1.

Verification
REQ-032 Write addr 2, wdata 32'hAABBCCDD, mask 4'hF; then read addr 2 -> io_out 32'hAABBCCDD two cycles after the read, io_wr_count = 1.
REQ-033 Preload addr 5 = 32'h11223344; write addr 5, wdata 32'hFFFFFFFF, mask 4'b0101; then read -> 32'h11FF33FF; with RETURN_NEW=0 the write's own response = 32'h11223344, with RETURN_NEW=1 = 32'h11FF33FF.
REQ-034 Back-to-back cycles: write addr 3 data 32'h000000AA mask 4'h1, write addr 3 data 32'h0000BB00 mask 4'h2, read addr 3 -> low 16 bits = 16'hBBAA, responses in three consecutive cycles.
REQ-035 DEPTH=6, ADDR_W=3: write addr 7 mask 4'hF -> io_err = 1, io_out = 0, io_wr_count unchanged; addr 0..5 contents unchanged.
REQ-036 Write addr 1 mask 4'h0 and read-only request with mask 4'hF -> memory unchanged, io_wr_count unchanged.
REQ-037 Assert reset_n low asynchronously while a write to addr 4 sits in S1 -> outputs clear immediately, addr 4 keeps its old value, io_wr_count = 0; pre-existing words at other addresses retained.
